// File: rtl/lasernet_serial_pkg.sv
// Shared definitions for the laser-link serial transmitter and receiver, so both
// ends agree on state encodings, default framing parameters and line levels.
package lasernet_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned DEF_CLK_PER_BIT = 50;
  localparam int unsigned DEF_PKT_LENGTH  = 32;

  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;

  localparam int unsigned BIT_CTR_W = 14;

endpackage

// File: rtl/serial_tx_if.sv
// Valid/ready payload handshake between packet generation and the serial transmitter.
interface serial_tx_if
  import lasernet_serial_pkg::*;
#(
  parameter int unsigned PKT_LENGTH = DEF_PKT_LENGTH
);

  logic [PKT_LENGTH-1:0] data;
  logic                  new_data;
  logic                  ready;
  logic                  busy;
  logic                  done;

  modport master (
    output data,
    output new_data,
    input  ready,
    input  busy,
    input  done
  );

  modport slave (
    input  data,
    input  new_data,
    output ready,
    output busy,
    output done
  );

endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period timer: free-runs 0..CLK_PER_BIT-1 and ticks on the last clock of each
// period; held at zero while clear is high.
module serial_bit_timer
  import lasernet_serial_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  logic [CW-1:0] ctr;

  assign tick = (ctr == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ctr <= '0;
    end else if (tick) begin
      ctr <= '0;
    end else begin
      ctr <= ctr + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Laser-link serial transmitter: high start bit, LSB-first payload, low stop period.
// The line output comes straight from a flop.
module serial_tx
  import lasernet_serial_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int unsigned PKT_LENGTH  = DEF_PKT_LENGTH,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  serial_tx_if.slave   bus,
  output logic         tx
);

  localparam logic [BIT_CTR_W-1:0] DATA_LAST = BIT_CTR_W'(PKT_LENGTH - 1);
  localparam logic [BIT_CTR_W-1:0] STOP_LAST = BIT_CTR_W'(STOP_BITS - 1);

  state_t                 state_q, state_d;
  logic [PKT_LENGTH-1:0]  shift_q, shift_d;
  logic [BIT_CTR_W-1:0]   bit_ctr_q, bit_ctr_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   tick;
  logic                   frame_end;
  logic                   ready;
  logic                   accept;

  serial_bit_timer #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  // ready also covers the final stop clock so a waiting source is taken on the
  // same edge the frame ends, keeping the inter-frame gap at exactly the stop period.
  assign frame_end = (state_q == STOP) && tick && (bit_ctr_q == STOP_LAST);
  assign ready     = (state_q == IDLE) || frame_end;
  assign accept    = bus.new_data && ready;

  assign bus.ready = ready;
  assign bus.busy  = ~ready;
  assign bus.done  = done_q;
  assign tx        = tx_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_ctr_d = bit_ctr_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = LINE_IDLE;
      end
      START: begin
        if (tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_ctr_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_ctr_q == DATA_LAST) begin
            tx_d      = LINE_IDLE;
            bit_ctr_d = '0;
            state_d   = STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_ctr_d = bit_ctr_q + BIT_CTR_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_ctr_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_ctr_d = bit_ctr_q + BIT_CTR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase

    if (accept) begin
      shift_d   = bus.data;
      bit_ctr_d = '0;
      tx_d      = LINE_START;
      state_d   = START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_ctr_q <= '0;
      tx_q      <= LINE_IDLE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_ctr_q <= bit_ctr_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx with CLK_PER_BIT=4, PKT_LENGTH=8, STOP_BITS=1 (40-cycle frames).
module tb_serial_tx;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  int unsigned total = 0;
  int unsigned bad   = 0;

  serial_tx_if #(.PKT_LENGTH(8)) bus ();

  serial_tx #(
    .CLK_PER_BIT(4),
    .PKT_LENGTH (8),
    .STOP_BITS  (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .tx (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; waits (bounded) for ready, presents d, returns after accept edge E0.
  task automatic accept(input logic [7:0] d);
    int unsigned n = 0;
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(bus.ready), 32'd1);
    bus.data     = d;
    bus.new_data = 1'b1;
    @(posedge clk);
  endtask

  // Samples cycles 0..last_k after E0 against the hand-derived line pattern.
  task automatic frame(input logic [7:0] d, input bit keep_nd, input bit exp_done0,
                       input int unsigned poke, input bit scramble, input int unsigned last_k);
    logic exp_tx;
    for (int unsigned k = 0; k <= last_k; k++) begin
      @(negedge clk);
      if (k == 0 && !keep_nd) bus.new_data = 1'b0;
      if (k < 4)       exp_tx = 1'b1;
      else if (k < 36) exp_tx = d[(k - 4) / 4];
      else             exp_tx = 1'b0;
      check($sformatf("tx_k%0d", k), 32'(tx), 32'(exp_tx));
      check($sformatf("done_k%0d", k), 32'(bus.done), (k == 0) ? 32'(exp_done0) : 32'd0);
      if (k == 0 || k == 20) begin
        check($sformatf("ready_k%0d", k), 32'(bus.ready), 32'd0);
        check($sformatf("busy_k%0d", k), 32'(bus.busy), 32'd1);
      end
      if (k == 39) check("ready_k39", 32'(bus.ready), 32'd1);
      if (scramble) bus.data = 8'($urandom);
      if (poke != 0 && k == poke) begin
        bus.data     = 8'h3C;
        bus.new_data = 1'b1;
      end
      if (poke != 0 && k == poke + 1) bus.new_data = 1'b0;
    end
  endtask

  // Samples the cycle after a frame edge (cycle 40) and then a quiet idle stretch.
  task automatic idle_after(input bit exp_done, input int unsigned n);
    @(negedge clk);
    check("end_done", 32'(bus.done), 32'(exp_done));
    check("end_ready", 32'(bus.ready), 32'd1);
    check("end_busy", 32'(bus.busy), 32'd0);
    check("end_tx", 32'(tx), 32'd0);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd0);
      check("idle_done", 32'(bus.done), 32'd0);
      check("idle_ready", 32'(bus.ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.data     = '0;
    bus.new_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    bus.new_data = 1'b0;
    rst          = 1'b0;
    @(negedge clk);

    // Single frame 8'hA5.
    accept(8'hA5);
    frame(8'hA5, 1'b0, 1'b0, 0, 1'b0, 39);
    idle_after(1'b1, 3);

    // Back-to-back with new_data held: frames at 0, 40, 80, 4-cycle low gap.
    accept(8'h01);
    frame(8'h01, 1'b1, 1'b0, 0, 1'b0, 39);
    bus.data = 8'h80;
    frame(8'h80, 1'b1, 1'b1, 0, 1'b0, 39);
    bus.data = 8'hFF;
    frame(8'hFF, 1'b0, 1'b1, 0, 1'b0, 39);
    idle_after(1'b1, 3);

    // new_data pulse with 8'h3C mid-frame is ignored.
    accept(8'h96);
    frame(8'h96, 1'b0, 1'b0, 10, 1'b0, 39);
    idle_after(1'b1, 12);

    // Reset at cycle 17 abandons the frame without a done pulse.
    accept(8'h5A);
    frame(8'h5A, 1'b0, 1'b0, 0, 1'b0, 17);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd0);
    check("mid_rst_ready", 32'(bus.ready), 32'd1);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    idle_after(1'b0, 30);
    accept(8'hC3);
    frame(8'hC3, 1'b0, 1'b0, 0, 1'b0, 39);
    idle_after(1'b1, 3);

    // Payload scrambled every cycle after capture.
    accept(8'h4B);
    frame(8'h4B, 1'b0, 1'b0, 0, 1'b1, 39);
    idle_after(1'b1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
